// File: rtl/ddr_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_cmd_pkg
// Purpose  : Shared command bit indices and power-state encoding for DDR4 blocks.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_cmd_pkg;

  localparam int NUM_CMDS = 19;

  localparam int CMD_ACT  = 0;
  localparam int CMD_BST  = 1;
  localparam int CMD_CFG  = 2;
  localparam int CMD_CKEH = 3;
  localparam int CMD_CKEL = 4;
  localparam int CMD_DPD  = 5;
  localparam int CMD_DPDX = 6;
  localparam int CMD_MRR  = 7;
  localparam int CMD_MRW  = 8;
  localparam int CMD_PD   = 9;
  localparam int CMD_PDX  = 10;
  localparam int CMD_PR   = 11;
  localparam int CMD_PRA  = 12;
  localparam int CMD_RD   = 13;
  localparam int CMD_RDA  = 14;
  localparam int CMD_REF  = 15;
  localparam int CMD_SRF  = 16;
  localparam int CMD_WR   = 17;
  localparam int CMD_WRA  = 18;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    POWERDOWN = 2'd1,
    SELFREF   = 2'd2
  } pwr_state_e;

endpackage
`default_nettype wire

// File: rtl/bank_state_table.sv
`default_nettype none
// ============================================================================
// Module   : bank_state_table
// Purpose  : Per-bank open flag and open-row storage with lookup and any-open.
// Revision : 1.0 - initial release
// ============================================================================
module bank_state_table #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  localparam int BGWIDTH      = $clog2(BANKGROUPS),
  localparam int BAWIDTH      = $clog2(BANKSPERGROUP)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_en,
  input  logic                 clr_en,
  input  logic                 clr_all,
  input  logic [BGWIDTH-1:0]   upd_bg,
  input  logic [BAWIDTH-1:0]   upd_ba,
  input  logic [ADDRWIDTH-1:0] set_row,
  input  logic [BGWIDTH-1:0]   lk_bg,
  input  logic [BAWIDTH-1:0]   lk_ba,
  output logic                 lk_open,
  output logic [ADDRWIDTH-1:0] lk_row,
  output logic                 any_open
);

  localparam int IDXW   = BGWIDTH + BAWIDTH;
  localparam int NBANKS = 1 << IDXW;

  logic                 r_open [NBANKS];
  logic [ADDRWIDTH-1:0] r_row  [NBANKS];
  logic [IDXW-1:0]      w_upd_idx;
  logic [IDXW-1:0]      w_lk_idx;
  logic                 w_any;

  assign w_upd_idx = {upd_bg, upd_ba};
  assign w_lk_idx  = {lk_bg, lk_ba};

  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
    localparam logic [IDXW-1:0] c_idx = IDXW'(gi);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_open[gi] <= 1'b0;
        r_row[gi]  <= '0;
      end else if (clr_all) begin
        r_open[gi] <= 1'b0;
      end else if (w_upd_idx == c_idx) begin
        if (set_en) begin
          r_open[gi] <= 1'b1;
          r_row[gi]  <= set_row;
        end else if (clr_en) begin
          r_open[gi] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < NBANKS; i++) begin
      w_any = w_any | r_open[i];
    end
  end

  assign any_open = w_any;
  assign lk_open  = r_open[w_lk_idx];
  assign lk_row   = r_row[w_lk_idx];

endmodule
`default_nettype wire

// File: rtl/ddr4_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_cmd_decoder
// Purpose  : DDR4 pin decode to one-hot commands, bank tracking, power FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_cmd_decoder
  import ddr_cmd_pkg::*;
#(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int COLS          = 1024,
  localparam int BGWIDTH      = $clog2(BANKGROUPS),
  localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
  localparam int CADDRWIDTH   = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  act_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BGWIDTH-1:0]    bg,
  input  logic [BAWIDTH-1:0]    ba_in,
  input  logic [ADDRWIDTH-1:0]  a,
  output logic [NUM_CMDS-1:0]   commands,
  output logic [BGWIDTH-1:0]    bg_out,
  output logic [BAWIDTH:0]      ba,
  output logic [ADDRWIDTH-1:0]  row,
  output logic [CADDRWIDTH-1:0] column,
  output logic                  illegal,
  output logic                  lowpower
);

  localparam int c_ap_bit = 10;

  pwr_state_e r_state;
  pwr_state_e w_state_nxt;
  logic       r_cke_prev;

  logic [NUM_CMDS-1:0]   r_commands;
  logic [BGWIDTH-1:0]    r_bg;
  logic [BAWIDTH:0]      r_ba;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [CADDRWIDTH-1:0] r_col;
  logic                  r_illegal;

  logic [NUM_CMDS-1:0]   w_cmd;
  logic                  w_illegal;
  logic                  w_addr_vld;
  logic [ADDRWIDTH-1:0]  w_row;
  logic [CADDRWIDTH-1:0] w_col;
  logic                  w_set;
  logic                  w_clr;
  logic                  w_clr_all;
  logic                  w_lk_open;
  logic [ADDRWIDTH-1:0]  w_lk_row;
  logic                  w_any_open;
  logic [2:0]            w_rcw;
  logic                  w_is_ref;
  logic                  w_ap;

  assign w_rcw    = {ras_n, cas_n, we_n};
  assign w_ap     = a[c_ap_bit];
  assign w_is_ref = !cs_n && act_n && (w_rcw == 3'b001);

  bank_state_table #(
    .ADDRWIDTH    (ADDRWIDTH),
    .BANKGROUPS   (BANKGROUPS),
    .BANKSPERGROUP(BANKSPERGROUP)
  ) u_bank_state_table (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (w_set),
    .clr_en  (w_clr),
    .clr_all (w_clr_all),
    .upd_bg  (bg),
    .upd_ba  (ba_in),
    .set_row (a),
    .lk_bg   (bg),
    .lk_ba   (ba_in),
    .lk_open (w_lk_open),
    .lk_row  (w_lk_row),
    .any_open(w_any_open)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = '0;
    w_illegal   = 1'b0;
    w_addr_vld  = 1'b0;
    w_row       = '0;
    w_col       = '0;
    w_set       = 1'b0;
    w_clr       = 1'b0;
    w_clr_all   = 1'b0;
    if (!halt) begin
      case (r_state)
        ACTIVE: begin
          // A cke falling edge wins over decode; only a clean REF turns it into SRF.
          if (r_cke_prev && !cke) begin
            if (w_is_ref && !w_any_open) begin
              w_cmd[CMD_SRF] = 1'b1;
              w_state_nxt    = SELFREF;
            end else begin
              w_cmd[CMD_PD]  = 1'b1;
              w_state_nxt    = POWERDOWN;
            end
          end else if (cke && !cs_n) begin
            if (!act_n) begin
              if (w_lk_open) begin
                w_illegal = 1'b1;
              end else begin
                w_cmd[CMD_ACT] = 1'b1;
                w_set          = 1'b1;
                w_row          = a;
                w_addr_vld     = 1'b1;
              end
            end else begin
              case (w_rcw)
                3'b000: begin
                  w_cmd[CMD_MRW] = 1'b1;
                  w_addr_vld     = 1'b1;
                end
                3'b001: begin
                  if (w_any_open) begin
                    w_illegal = 1'b1;
                  end else begin
                    w_cmd[CMD_REF] = 1'b1;
                    w_addr_vld     = 1'b1;
                  end
                end
                3'b010: begin
                  w_addr_vld = 1'b1;
                  if (w_ap) begin
                    w_cmd[CMD_PRA] = 1'b1;
                    w_clr_all      = 1'b1;
                  end else begin
                    w_cmd[CMD_PR]  = 1'b1;
                    w_clr          = 1'b1;
                  end
                end
                3'b100, 3'b101: begin
                  if (!w_lk_open) begin
                    w_illegal = 1'b1;
                  end else begin
                    w_addr_vld = 1'b1;
                    w_row      = w_lk_row;
                    w_col      = a[CADDRWIDTH-1:0];
                    w_clr      = w_ap;
                    if (w_rcw == 3'b100) begin
                      w_cmd[w_ap ? CMD_WRA : CMD_WR] = 1'b1;
                    end else begin
                      w_cmd[w_ap ? CMD_RDA : CMD_RD] = 1'b1;
                    end
                  end
                end
                3'b110: begin
                  w_cmd[CMD_CFG] = 1'b1;
                  w_addr_vld     = 1'b1;
                end
                3'b011: begin
                  w_illegal = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          if (!r_cke_prev && cke) begin
            w_cmd[CMD_PDX] = 1'b1;
            w_state_nxt    = ACTIVE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ACTIVE;
      r_cke_prev <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (!halt) begin
        r_cke_prev <= cke;
      end
    end
  end

  // Under halt the combinational decode is all zero, so outputs clear naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_commands <= '0;
      r_illegal  <= 1'b0;
      r_bg       <= '0;
      r_ba       <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_commands <= w_cmd;
      r_illegal  <= w_illegal;
      r_bg       <= w_addr_vld ? bg : '0;
      r_ba       <= w_addr_vld ? {1'b0, ba_in} : '0;
      r_row      <= w_row;
      r_col      <= w_col;
    end
  end

  assign commands = r_commands;
  assign illegal  = r_illegal;
  assign bg_out   = r_bg;
  assign ba       = r_ba;
  assign row      = r_row;
  assign column   = r_col;
  assign lowpower = (r_state != ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_cmd_decoder
// Purpose  : Directed plus randomized self-checking bench against a bank/power model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_cmd_decoder;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt    = 1'b0;
  logic        cke     = 1'b1;
  logic        cs_n    = 1'b1;
  logic        act_n   = 1'b1;
  logic        ras_n   = 1'b1;
  logic        cas_n   = 1'b1;
  logic        we_n    = 1'b1;
  logic [1:0]  bg      = '0;
  logic [1:0]  ba_in   = '0;
  logic [16:0] a       = '0;

  logic [18:0] commands;
  logic [1:0]  bg_out;
  logic [2:0]  ba;
  logic [16:0] row;
  logic [9:0]  column;
  logic        illegal;
  logic        lowpower;

  int checks   = 0;
  int failures = 0;

  ddr4_cmd_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .halt    (halt),
    .cke     (cke),
    .cs_n    (cs_n),
    .act_n   (act_n),
    .ras_n   (ras_n),
    .cas_n   (cas_n),
    .we_n    (we_n),
    .bg      (bg),
    .ba_in   (ba_in),
    .a       (a),
    .commands(commands),
    .bg_out  (bg_out),
    .ba      (ba),
    .row     (row),
    .column  (column),
    .illegal (illegal),
    .lowpower(lowpower)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_open [16];
  logic [16:0] m_row  [16];
  int          m_pwr;        // 0 active, 1 power-down, 2 self-refresh
  bit          m_ckep;
  logic [18:0] e_cmd;
  bit          e_ill;
  logic [16:0] e_row;
  logic [9:0]  e_col;
  logic [1:0]  e_bg;
  logic [2:0]  e_ba;
  bit          e_row_chk;
  bit          e_addr_chk;
  int          m_bi;
  int          m_nopen;
  bit          m_isref;
  logic [2:0]  m_rcw;

  always @(posedge clk or negedge reset_n) begin
    e_cmd = '0; e_ill = 1'b0; e_row = '0; e_col = '0; e_bg = '0; e_ba = '0;
    e_row_chk = 1'b0; e_addr_chk = 1'b0;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin m_open[i] = 1'b0; m_row[i] = '0; end
      m_pwr = 0; m_ckep = 1'b1;
      e_row_chk = 1'b1; e_addr_chk = 1'b1;
    end else if (!halt) begin
      m_bi    = int'(bg) * 4 + int'(ba_in);
      m_nopen = 0;
      for (int i = 0; i < 16; i++) m_nopen += int'(m_open[i]);
      m_rcw   = {ras_n, cas_n, we_n};
      m_isref = !cs_n && act_n && m_rcw == 3'b001;
      if (m_pwr == 0) begin
        if (m_ckep && !cke) begin
          if (m_isref && m_nopen == 0) begin e_cmd[16] = 1'b1; m_pwr = 2; end
          else begin e_cmd[9] = 1'b1; m_pwr = 1; end
        end else if (cke && !cs_n) begin
          e_bg = bg; e_ba = {1'b0, ba_in};
          if (!act_n) begin
            if (m_open[m_bi]) e_ill = 1'b1;
            else begin
              e_cmd[0] = 1'b1; m_open[m_bi] = 1'b1; m_row[m_bi] = a;
              e_row = a; e_row_chk = 1'b1; e_addr_chk = 1'b1;
            end
          end else begin
            case (m_rcw)
              3'd0: e_cmd[8] = 1'b1;
              3'd1: if (m_nopen > 0) e_ill = 1'b1; else e_cmd[15] = 1'b1;
              3'd2: begin
                e_addr_chk = 1'b1;
                if (a[10]) begin
                  e_cmd[12] = 1'b1;
                  for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
                end else begin
                  e_cmd[11] = 1'b1; m_open[m_bi] = 1'b0;
                end
              end
              3'd3: e_ill = 1'b1;
              3'd4, 3'd5: begin
                if (!m_open[m_bi]) e_ill = 1'b1;
                else begin
                  if (m_rcw == 3'd4) e_cmd[a[10] ? 18 : 17] = 1'b1;
                  else               e_cmd[a[10] ? 14 : 13] = 1'b1;
                  e_row = m_row[m_bi]; e_col = a[9:0];
                  e_row_chk = 1'b1; e_addr_chk = 1'b1;
                  if (a[10]) m_open[m_bi] = 1'b0;
                end
              end
              3'd6: e_cmd[2] = 1'b1;
              default: ;
            endcase
          end
        end
      end else if (!m_ckep && cke) begin
        e_cmd[10] = 1'b1; m_pwr = 0;
      end
      m_ckep = cke;
    end
    #1;
    chk("m_commands", 32'(commands), 32'(e_cmd));
    chk("m_illegal", 32'(illegal), 32'(e_ill));
    chk("m_column", 32'(column), 32'(e_col));
    chk("m_lowpower", 32'(lowpower), 32'(m_pwr != 0));
    if (e_row_chk) chk("m_row", 32'(row), 32'(e_row));
    if (e_addr_chk) begin
      chk("m_bg_out", 32'(bg_out), 32'(e_bg));
      chk("m_ba", 32'(ba), 32'(e_ba));
    end
  end

  task automatic cyc(input logic k, input logic cs, input logic actn, input logic [2:0] rcw,
                     input int g, input int b, input int addr);
    cke = k; cs_n = cs; act_n = actn; {ras_n, cas_n, we_n} = rcw;
    bg = 2'(g); ba_in = 2'(b); a = 17'(addr);
    @(posedge clk); #2;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_commands", 32'(commands), 32'h0);
    chk("rst_lowpower", 32'(lowpower), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    reset_n = 1'b1;

    cyc(1, 0, 0, 3'b111, 1, 2, 'h1ABC);
    chk("act_cmd", 32'(commands), 32'h1);
    chk("act_row", 32'(row), 32'h1ABC);
    chk("act_ba", 32'(ba), 32'h2);
    chk("act_bg", 32'(bg_out), 32'h1);
    cyc(1, 0, 1, 3'b101, 1, 2, 'h05A);
    chk("rd_cmd", 32'(commands), 32'h2000);
    chk("rd_row", 32'(row), 32'h1ABC);
    chk("rd_col", 32'(column), 32'h05A);
    cyc(1, 0, 1, 3'b100, 1, 2, 'h411);
    chk("wra_cmd", 32'(commands), 32'h40000);
    chk("wra_col", 32'(column), 32'h011);
    cyc(1, 0, 1, 3'b101, 1, 2, 'h05A);
    chk("rd_closed_ill", 32'(illegal), 32'h1);
    chk("rd_closed_cmd", 32'(commands), 32'h0);

    cyc(1, 0, 0, 3'b111, 0, 0, 'h10);
    cyc(1, 0, 0, 3'b111, 3, 3, 'h20);
    cyc(1, 0, 1, 3'b010, 0, 0, 'h400);
    chk("pra_cmd", 32'(commands), 32'h1000);
    cyc(1, 0, 1, 3'b001, 0, 0, 0);
    chk("ref_cmd", 32'(commands), 32'h8000);
    chk("ref_ill", 32'(illegal), 32'h0);

    cyc(1, 0, 0, 3'b111, 0, 0, 'h33);
    cyc(0, 0, 1, 3'b001, 0, 0, 0);
    chk("pd_cmd", 32'(commands), 32'h200);
    chk("pd_lp", 32'(lowpower), 32'h1);
    cyc(1, 1, 1, 3'b111, 0, 0, 0);
    chk("pdx_cmd", 32'(commands), 32'h400);
    chk("pdx_lp", 32'(lowpower), 32'h0);
    cyc(1, 0, 1, 3'b010, 0, 0, 0);
    chk("pr_cmd", 32'(commands), 32'h800);
    cyc(0, 0, 1, 3'b001, 0, 0, 0);
    chk("srf_cmd", 32'(commands), 32'h10000);
    chk("srf_lp", 32'(lowpower), 32'h1);
    cyc(0, 0, 0, 3'b111, 0, 0, 0);
    chk("srf_ignore", 32'(commands), 32'h0);
    cyc(1, 1, 1, 3'b111, 0, 0, 0);
    chk("srx_cmd", 32'(commands), 32'h400);
    chk("srx_lp", 32'(lowpower), 32'h0);

    cyc(1, 0, 1, 3'b011, 0, 0, 0);
    chk("rsv_ill", 32'(illegal), 32'h1);
    chk("rsv_cmd", 32'(commands), 32'h0);

    halt = 1'b1;
    cyc(1, 0, 0, 3'b111, 2, 1, 'h55);
    chk("halt_cmd", 32'(commands), 32'h0);
    halt = 1'b0;
    cyc(1, 0, 1, 3'b101, 2, 1, 0);
    chk("halt_no_open", 32'(illegal), 32'h1);

    cyc(1, 0, 0, 3'b111, 1, 1, 'h77);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_cmd", 32'(commands), 32'h0);
    chk("arst_row", 32'(row), 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    cyc(1, 0, 1, 3'b101, 1, 1, 0);
    chk("arst_rd_ill", 32'(illegal), 32'h1);

    cyc(1, 1, 1, 3'b111, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if (cke) cke = ($urandom_range(0, 19) != 0);
      else     cke = ($urandom_range(0, 3) == 0);
      halt  = ($urandom_range(0, 31) == 0);
      cs_n  = ($urandom_range(0, 4) == 0);
      act_n = ($urandom_range(0, 3) != 0);
      {ras_n, cas_n, we_n} = 3'($urandom_range(0, 7));
      bg    = 2'($urandom_range(0, 3));
      ba_in = 2'($urandom_range(0, 3));
      a     = 17'($urandom);
      @(posedge clk); #2;
    end
    halt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
